regfile_writeback_queue: RTL and testbench

Write-side companion to the 32×64 register file: collects register writes from the datapath on a valid/ready port, buffers up to DEPTH of them in a FIFO, and drains one per cycle onto the register file's write port (RegWr/RW/BusW). Pending writes are forwarded on the two read ports, so BusA/BusB always return the newest value, whether it is still queued or already in the register file. Sits between the writeback mux and the register file. Writes to X31 are accepted and discarded.

---
 rtl/regfile_writeback_queue.sv | 92 +++++++++
 tb/tb_regfile_writeback_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// Write-side FIFO in front of the 32x64 register file: buffers datapath writes, drains one per
// cycle onto the write port, and forwards pending values onto the two read ports.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       Clk,
  input  logic                       ResetL,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [4:0]                 InRW,
  input  logic [WIDTH-1:0]           InData,
  input  logic                       DrainEn,
  output logic                       RegWr,
  output logic [4:0]                 RW,
  output logic [WIDTH-1:0]           BusW,
  input  logic [4:0]                 RA,
  input  logic [4:0]                 RB,
  input  logic [WIDTH-1:0]           BusAIn,
  input  logic [WIDTH-1:0]           BusBIn,
  output logic [WIDTH-1:0]           BusA,
  output logic [WIDTH-1:0]           BusB,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]       mem_rw   [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic accept, store, pop;

  assign Count   = count_q;
  assign Empty   = (count_q == '0);
  assign InReady = (count_q != CntW'(DEPTH));
  assign accept  = InValid && InReady;
  // X31 is the zero register: consume the request but never queue it
  assign store   = accept && (InRW != 5'd31);
  assign RegWr   = !Empty && DrainEn;
  assign pop     = RegWr;
  assign RW      = Empty ? 5'd0 : mem_rw[head_q];
  assign BusW    = Empty ? '0 : mem_data[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CntW'(store) - CntW'(pop);
    if (store) tail_d = tail_q + PtrW'(1);
    if (pop)   head_d = head_q + PtrW'(1);
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (store) begin
      mem_rw[tail_q]   <= InRW;
      mem_data[tail_q] <= InData;
    end
  end

  // Walk from head to tail so the newest matching entry overwrites older ones
  always_comb begin
    logic [PtrW-1:0] slot;
    BusA = BusAIn;
    BusB = BusBIn;
    slot = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head_q + PtrW'(k);
      if (CntW'(k) < count_q) begin
        if (RA != 5'd31 && mem_rw[slot] == RA) BusA = mem_data[slot];
        if (RB != 5'd31 && mem_rw[slot] == RB) BusB = mem_data[slot];
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: stimulus pushes expected writes, a negedge
// monitor pops and compares every register-file write.
module tb_regfile_writeback_queue;

  logic        Clk = 1'b0;
  logic        ResetL = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  InRW = '0;
  logic [63:0] InData = '0;
  logic        DrainEn = 1'b0;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic [4:0]  RA = '0;
  logic [4:0]  RB = '0;
  logic [63:0] BusAIn = '0;
  logic [63:0] BusBIn = '0;
  logic [63:0] BusA;
  logic [63:0] BusB;
  logic [2:0]  Count;
  logic        Empty;

  regfile_writeback_queue #(.DEPTH(4), .WIDTH(64)) dut (
    .Clk(Clk), .ResetL(ResetL), .InValid(InValid), .InReady(InReady), .InRW(InRW),
    .InData(InData), .DrainEn(DrainEn), .RegWr(RegWr), .RW(RW), .BusW(BusW), .RA(RA), .RB(RB),
    .BusAIn(BusAIn), .BusBIn(BusBIn), .BusA(BusA), .BusB(BusB), .Count(Count), .Empty(Empty)
  );

  always #5 Clk = ~Clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned wr_count = 0;
  logic [68:0] exp_q [$];
  logic [63:0] regs [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Register-file model and scoreboard monitor
  always @(negedge Clk) begin
    if (RegWr === 1'b1) begin
      logic [68:0] e;
      wr_count++;
      regs[RW] = BusW;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got RW=%0d BusW=0x%0h expected no write", RW, BusW);
      end else begin
        e = exp_q.pop_front();
        chk("drain_rw", {59'd0, RW}, {59'd0, e[68:64]});
        chk("drain_data", BusW, e[63:0]);
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1
  task automatic enq(input logic [4:0] rw, input logic [63:0] d, output logic accepted);
    InValid = 1'b1; InRW = rw; InData = d;
    @(negedge Clk);
    accepted = InReady;
    @(posedge Clk);
    if (accepted && rw != 5'd31) exp_q.push_back({rw, d});
    #1 InValid = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    int unsigned cyc = 0;
    while ((Empty !== 1'b1 || exp_q.size() != 0) && cyc < 50) begin
      @(posedge Clk); #1; cyc++;
    end
    chk(name, {63'd0, (Empty === 1'b1 && exp_q.size() == 0)}, 64'd1);
  endtask

  initial begin
    logic acc;
    int unsigned wr_snap;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    // Reset state
    #12;
    chk("rst_count", {61'd0, Count}, 64'd0);
    chk("rst_empty", {63'd0, Empty}, 64'd1);
    chk("rst_inready", {63'd0, InReady}, 64'd1);
    chk("rst_regwr", {63'd0, RegWr}, 64'd0);
    @(posedge Clk); #1 ResetL = 1'b1;

    // Single write
    DrainEn = 1'b1;
    enq(5'd5, 64'h1234, acc);
    @(negedge Clk);
    chk("single_regwr", {63'd0, RegWr}, 64'd1);
    chk("single_rw", {59'd0, RW}, 64'd5);
    chk("single_busw", BusW, 64'h1234);
    @(negedge Clk);
    chk("single_empty", {63'd0, Empty}, 64'd1);
    RA = 5'd5; BusAIn = regs[5]; #1;
    chk("single_readback", BusA, 64'h1234);

    // Fill to full with draining held
    @(posedge Clk); #1;
    DrainEn = 1'b0;
    for (int i = 1; i <= 4; i++) enq(5'(i), 64'h100 + 64'(i), acc);
    chk("full_count", {61'd0, Count}, 64'd4);
    chk("full_inready", {63'd0, InReady}, 64'd0);
    enq(5'd9, 64'hDEAD, acc);
    chk("full_reject", {63'd0, acc}, 64'd0);
    chk("full_count_hold", {61'd0, Count}, 64'd4);
    DrainEn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge Clk);
      chk("full_drain_en", {63'd0, RegWr}, 64'd1);
      chk("full_drain_rw", {59'd0, RW}, 64'(i));
    end
    @(posedge Clk); #1;
    wait_drained("full_drained");

    // Simultaneous push/pop at Count = 2 across pointer wrap
    DrainEn = 1'b0;
    enq(5'd10, 64'hA0, acc);
    enq(5'd11, 64'hA1, acc);
    DrainEn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      InValid = 1'b1; InRW = 5'(12 + (i % 8)); InData = 64'h5000 + 64'(i);
      @(negedge Clk);
      if (i % 4 == 0) chk("pushpop_count", {61'd0, Count}, 64'd2);
      @(posedge Clk);
      exp_q.push_back({InRW, InData});
      #1;
    end
    InValid = 1'b0;
    chk("pushpop_count_end", {61'd0, Count}, 64'd2);
    wait_drained("pushpop_drained");

    // Forwarding
    DrainEn = 1'b0;
    enq(5'd7, 64'hA, acc);
    enq(5'd7, 64'hB, acc);
    RA = 5'd7; BusAIn = 64'h99; RB = 5'd8; BusBIn = 64'h77; #1;
    chk("fwd_newest", BusA, 64'hB);
    chk("fwd_miss", BusB, 64'h77);
    RA = 5'd31; BusAIn = 64'h55; RB = 5'd7; #1;
    chk("fwd_x31", BusA, 64'h55);
    chk("fwd_b_newest", BusB, 64'hB);
    DrainEn = 1'b1; #1;
    chk("fwd_during_drain", BusB, 64'hB);
    @(posedge Clk); #1;
    chk("fwd_after_pop", BusB, 64'hB);
    wait_drained("fwd_drained");
    RB = 5'd7; BusBIn = 64'h33; #1;
    chk("fwd_gone", BusB, 64'h33);

    // X31 discard
    DrainEn = 1'b0;
    enq(5'd3, 64'h1, acc);
    enq(5'd31, 64'hFFFF, acc);
    chk("x31_accepted", {63'd0, acc}, 64'd1);
    chk("x31_count", {61'd0, Count}, 64'd1);
    chk("x31_inready", {63'd0, InReady}, 64'd1);
    DrainEn = 1'b1;
    wait_drained("x31_drained");

    // Reset mid-stream with 3 entries queued
    DrainEn = 1'b0;
    for (int i = 0; i < 3; i++) enq(5'(20 + i), 64'hC0 + 64'(i), acc);
    chk("mid_count", {61'd0, Count}, 64'd3);
    #2 ResetL = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_count", {61'd0, Count}, 64'd0);
    chk("mid_rst_regwr", {63'd0, RegWr}, 64'd0);
    chk("mid_rst_rw", {59'd0, RW}, 64'd0);
    chk("mid_rst_busw", BusW, 64'd0);
    wr_snap = wr_count;
    @(posedge Clk); #1 ResetL = 1'b1;
    DrainEn = 1'b1;
    repeat (6) @(negedge Clk);
    chk("mid_no_write", 64'(wr_count), 64'(wr_snap));
    chk("mid_empty", {63'd0, Empty}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
